// File: rtl/exe_unit_w2.sv
`default_nettype none
// ============================================================================
// Module   : exe_unit_w2
// Purpose  : Handshaked M-bit execution unit: single-cycle ALU ops plus an
//            iterative shift-add multiplier, registered result and status.
// Revision : 1.0
// ============================================================================
module exe_unit_w2 #(
  parameter int M = 8,
  parameter int N = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_oper,
  input  logic [M-1:0] i_argA,
  input  logic [M-1:0] i_argB,
  output logic [M-1:0] o_result,
  output logic [1:0]   o_status,
  output logic         o_valid
);

  localparam int CW = $clog2(M) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [N-1:0] OP_ADD = N'(0);
  localparam logic [N-1:0] OP_SUB = N'(1);
  localparam logic [N-1:0] OP_AND = N'(2);
  localparam logic [N-1:0] OP_OR  = N'(3);
  localparam logic [N-1:0] OP_XOR = N'(4);
  localparam logic [N-1:0] OP_SHL = N'(5);
  localparam logic [N-1:0] OP_MUL = N'(6);

  localparam logic [M-1:0]  M_VAL  = M'(M);
  localparam logic [CW-1:0] LAST_STEP = CW'(M - 1);

  logic [0:0]     state_q, state_d;
  logic [2*M-1:0] a_q, a_d;
  logic [M-1:0]   b_q, b_d;
  logic [2*M-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   result_q, result_d;
  logic [1:0]     status_q, status_d;
  logic           valid_q, valid_d;

  logic [M:0]     w_sum;
  logic [M-1:0]   w_shamt;
  logic [2*M-1:0] w_shl;
  logic [M-1:0]   w_sc_result;
  logic           w_ovf, w_ill;
  logic [1:0]     w_sc_status;
  logic [2*M-1:0] w_acc_next;
  logic           w_last;

  // Priority: illegal > overflow > zero > ok
  function automatic logic [1:0] f_status(input logic ill, input logic ovf,
                                          input logic [M-1:0] res);
    if (ill)              return 2'b11;
    else if (ovf)         return 2'b01;
    else if (res == '0)   return 2'b10;
    else                  return 2'b00;
  endfunction

  assign w_sum   = {1'b0, i_argA} + {1'b0, i_argB};
  assign w_shamt = i_argB % M_VAL;
  assign w_shl   = {{M{1'b0}}, i_argA} << w_shamt;

  always_comb begin
    w_sc_result = '0;
    w_ovf       = 1'b0;
    w_ill       = 1'b0;
    case (i_oper)
      OP_ADD: begin w_sc_result = w_sum[M-1:0]; w_ovf = w_sum[M]; end
      OP_SUB: begin w_sc_result = i_argA - i_argB; w_ovf = (i_argA < i_argB); end
      OP_AND: w_sc_result = i_argA & i_argB;
      OP_OR:  w_sc_result = i_argA | i_argB;
      OP_XOR: w_sc_result = i_argA ^ i_argB;
      OP_SHL: begin w_sc_result = w_shl[M-1:0]; w_ovf = |w_shl[2*M-1:M]; end
      OP_MUL: ;
      default: w_ill = 1'b1;
    endcase
    w_sc_status = f_status(w_ill, w_ovf, w_sc_result);
  end

  // A is pre-shifted and B consumed LSB-first, so each step only tests b_q[0]
  assign w_acc_next = acc_q + (b_q[0] ? a_q : '0);
  assign w_last     = (cnt_q == LAST_STEP);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid && (i_oper == OP_MUL)) state_d = BUSY;
      BUSY:    if (w_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready  = (state_q == IDLE);
    o_result = result_q;
    o_status = status_q;
    o_valid  = valid_q;
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    status_d = status_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (i_oper == OP_MUL) begin
            a_d   = {{M{1'b0}}, i_argA};
            b_d   = i_argB;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            result_d = w_sc_result;
            status_d = w_sc_status;
            valid_d  = 1'b1;
          end
        end
      end
      BUSY: begin
        acc_d = w_acc_next;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (w_last) begin
          result_d = w_acc_next[M-1:0];
          status_d = f_status(1'b0, |w_acc_next[2*M-1:M], w_acc_next[M-1:0]);
          valid_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      status_q <= 2'b00;
      valid_q  <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      status_q <= status_d;
      valid_q  <= valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_unit_w2.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_unit_w2
// Purpose  : Directed and randomized self-checking bench for exe_unit_w2.
// Revision : 1.0
// ============================================================================
module tb_exe_unit_w2;
  localparam int M = 8;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid_in = 1'b0;
  logic         ready;
  logic [N-1:0] oper = '0;
  logic [M-1:0] arg_a = '0;
  logic [M-1:0] arg_b = '0;
  logic [M-1:0] result;
  logic [1:0]   status;
  logic         valid_out;

  int total = 0;
  int bad   = 0;

  exe_unit_w2 #(.M(M), .N(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_in), .o_ready(ready),
    .i_oper(oper), .i_argA(arg_a), .i_argB(arg_b),
    .o_result(result), .o_status(status), .o_valid(valid_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int op, input int a, input int b);
    valid_in = 1'b1;
    oper     = N'(op);
    arg_a    = M'(a);
    arg_b    = M'(b);
  endtask

  // Reference: results computed with wide integer arithmetic, then reduced mod 2^M
  task automatic model(input int op, input int a, input int b,
                       output int res, output int st, output int lat);
    longint full;
    longint modv;
    bit ovf, ill;
    modv = longint'(1) << M;
    ovf = 0; ill = 0; full = 0; lat = 1;
    case (op)
      0: begin full = a + b; ovf = (full >= modv); end
      1: begin full = a - b + modv; ovf = (a < b); end
      2: full = a & b;
      3: full = a | b;
      4: full = a ^ b;
      5: begin full = longint'(a) * (longint'(1) << (b % M)); ovf = (full >= modv); end
      6: begin full = longint'(a) * b; ovf = (full >= modv); lat = M + 1; end
      default: ill = 1;
    endcase
    res = ill ? 0 : int'(full % modv);
    st  = ill ? 3 : ovf ? 1 : (res == 0) ? 2 : 0;
  endtask

  initial begin
    int res, st, lat, waited;

    // Reset with a request pending
    drive(0, 1, 1);
    tick(); tick();
    chk("rst_result", result, 0);
    chk("rst_status", status, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_ready", ready, 1);
    rst = 1'b0;
    valid_in = 1'b0;
    tick();
    chk("post_rst_valid", valid_out, 0);

    // Back-to-back ADD then SUB
    drive(0, 200, 100);
    tick();
    chk("add_result", result, 44);
    chk("add_status", status, 2'b01);
    chk("add_valid", valid_out, 1);
    drive(1, 5, 5);
    tick();
    chk("sub_result", result, 0);
    chk("sub_status", status, 2'b10);
    chk("sub_valid", valid_out, 1);
    valid_in = 1'b0;
    tick();
    chk("idle_valid", valid_out, 0);
    chk("hold_status", status, 2'b10);

    // SHL with amount wrap, XOR to zero
    drive(5, 8'h81, 9);
    tick();
    chk("shl_result", result, 8'h02);
    chk("shl_status", status, 2'b01);
    drive(4, 8'h5A, 8'h5A);
    tick();
    chk("xor_result", result, 0);
    chk("xor_status", status, 2'b10);
    valid_in = 1'b0;

    // MUL 15*17 with busy-window checks
    tick();
    drive(6, 15, 17);
    tick();
    valid_in = 1'b0;
    chk("mul_busy_ready0", ready, 0);
    chk("mul_busy_valid0", valid_out, 0);
    for (int i = 1; i < M; i++) begin
      tick();
      chk("mul_busy_ready", ready, 0);
    end
    tick();
    chk("mul_done_valid", valid_out, 1);
    chk("mul_done_ready", ready, 1);
    chk("mul_result", result, 255);
    chk("mul_status", status, 2'b00);

    // MUL overflow beats zero
    drive(6, 16, 16);
    tick();
    valid_in = 1'b0;
    repeat (M) tick();
    chk("mul16_valid", valid_out, 1);
    chk("mul16_result", result, 0);
    chk("mul16_status", status, 2'b01);

    // ADD held during BUSY is ignored, then accepted once ready
    drive(6, 3, 3);
    tick();
    drive(0, 1, 2);
    for (int i = 1; i < M; i++) begin
      tick();
      chk("mul3_busy_valid", valid_out, 0);
    end
    tick();
    chk("mul3_valid", valid_out, 1);
    chk("mul3_result", result, 9);
    chk("mul3_status", status, 0);
    chk("mul3_ready", ready, 1);
    tick();
    valid_in = 1'b0;
    chk("late_add_valid", valid_out, 1);
    chk("late_add_result", result, 3);

    // Illegal opcode
    drive(7, 8'hFF, 8'hFF);
    tick();
    valid_in = 1'b0;
    chk("ill_result", result, 0);
    chk("ill_status", status, 2'b11);

    // Reset during 4th BUSY cycle aborts the multiply
    drive(6, 7, 9);
    tick();
    valid_in = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", valid_out, 0);
    chk("abort_result", result, 0);
    chk("abort_status", status, 0);
    chk("abort_ready", ready, 1);
    for (int i = 0; i < M + 2; i++) begin
      tick();
      chk("abort_no_pulse", valid_out, 0);
    end

    // Randomized operations against the reference
    for (int n = 0; n < 60; n++) begin
      int op, a, b;
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, (1 << M) - 1));
      b  = int'($urandom_range(0, (1 << M) - 1));
      if (n % 5 == 0) b = a;
      model(op, a, b, res, st, lat);
      drive(op, a, b);
      tick();
      valid_in = 1'b0;
      waited = 1;
      while (!valid_out && waited < 3 * M) begin
        tick();
        waited++;
      end
      chk("rnd_latency", waited, lat);
      chk("rnd_result", result, res);
      chk("rnd_status", status, st);
      tick();
      chk("rnd_pulse_end", valid_out, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
